// File: rtl/lsp_cb_stream.sv
// LSP scalar codebook ROM and valid/ready streamer for the Codec2 2400 quantiser.
// Define LSP_CB_NEAREST_EN to add the nearest-entry search (best_idx/best_err).
module lsp_cb_stream #(
  parameter int                  N         = 32,
  parameter int                  NUM_CB    = 10,
  parameter int                  MAX_LOG2  = 4,
  parameter logic [4*NUM_CB-1:0] CB_BITS   = 40'h2334444444,
  parameter string               INIT_FILE = "lsp_cb.mem"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          cb_sel,
  input  logic [N-1:0]        target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_data,
  output logic [MAX_LOG2-1:0] out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                sel_err,
  output logic [MAX_LOG2-1:0] best_idx,
  output logic [N:0]          best_err
);

  localparam int ROM_DEPTH = NUM_CB << MAX_LOG2;
  localparam int AW        = $clog2(ROM_DEPTH);
  localparam int IW        = MAX_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

  // The codebook image is compiled in (Hz values, Q.16); INIT_FILE names the matching image.
  logic unused_cfg;
  assign unused_cfg = (INIT_FILE == "");

  function automatic logic signed [N-1:0] rom_word(input logic [AW-1:0] addr);
    int cb;
    int i;
    int hz;
    cb = int'(addr) >> MAX_LOG2;
    i  = int'(addr) & ((1 << MAX_LOG2) - 1);
    case (cb)
      0:       hz = 225  + 25  * i;
      1:       hz = 325  + 25  * i;
      2:       hz = 500  + 50  * i;
      3:       hz = 700  + 50  * i;
      4:       hz = 950  + 50  * i;
      5:       hz = 1100 + 50  * i;
      6:       hz = 1500 + 100 * i;
      7:       hz = 2300 + 100 * i;
      8:       hz = 2500 + 100 * i;
      9:       hz = 2900 + 200 * i;
      default: hz = 0;
    endcase
    return N'(hz <<< 16);
  endfunction

  function automatic logic [IW-1:0] cb_last(input logic [3:0] cb);
    int f;
    f = int'(CB_BITS[4*int'(cb) +: 4]);
    return IW'((1 << f) - 1);
  endfunction

  state_t              state;
  logic [3:0]          cb_q;
  logic [IW-1:0]       last_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       rd_idx;
  logic [AW-1:0]       rd_addr;
  logic signed [N-1:0] rom_p1;
  logic                vld_p1;
  logic                last_p1;
  logic                sel_ok;
  logic                start_ok;
  logic                beat;
  logic                rom_en;

  assign sel_ok   = int'(cb_sel) < NUM_CB;
  assign start_ok = (state == S_IDLE) && start && sel_ok;
  assign beat     = (state == S_STREAM) && vld_p1 && out_ready;
  assign rom_en   = (state == S_FETCH) || beat;

  // Prefetch: the read address moves to idx+1 in the same cycle a beat is accepted.
  always_comb begin
    rd_idx = idx_q;
    if (beat && !last_p1) rd_idx = idx_q + 1'b1;
    rd_addr = AW'((int'(cb_q) << MAX_LOG2) + int'(rd_idx));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cb_q    <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      rom_p1  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      if (rom_en) rom_p1 <= rom_word(rd_addr);
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cb_q   <= cb_sel;
            last_q <= cb_last(cb_sel);
            idx_q  <= '0;
            busy   <= 1'b1;
            state  <= S_FETCH;
          end else if (start) begin
            sel_err <= 1'b1;
          end
        end
        S_FETCH: begin
          vld_p1  <= 1'b1;
          last_p1 <= (idx_q == last_q);
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (beat) begin
            if (last_p1) begin
              vld_p1  <= 1'b0;
              last_p1 <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              last_p1 <= ((idx_q + 1'b1) == last_q);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = rom_p1;
  assign out_idx   = idx_q;
  assign out_last  = last_p1;

`ifdef LSP_CB_NEAREST_EN
  function automatic logic [N:0] abs_diff(input logic signed [N-1:0] a,
                                          input logic signed [N-1:0] b);
    logic signed [N:0] d;
    d = $signed({a[N-1], a}) - $signed({b[N-1], b});
    return d[N] ? -d : d;
  endfunction

  logic signed [N-1:0] target_q;
  logic [IW-1:0]       best_idx_q;
  logic [N:0]          best_err_q;
  logic [N:0]          dist;

  assign dist = abs_diff(rom_p1, target_q);

  // Strict less-than keeps the lower index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q   <= '0;
      best_idx_q <= '0;
      best_err_q <= '0;
    end else begin
      if (start_ok) target_q <= target;
      if (beat && ((idx_q == '0) || (dist < best_err_q))) begin
        best_idx_q <= idx_q;
        best_err_q <= dist;
      end
    end
  end

  assign best_idx = best_idx_q;
  assign best_err = best_err_q;
`else
  logic unused_target;
  assign unused_target = ^target;
  assign best_idx      = '0;
  assign best_err      = '0;
`endif

endmodule

// File: tb/tb_lsp_cb_stream.sv
// Bench for lsp_cb_stream: vector table, random streams against a codebook model, corner sequences.
module tb_lsp_cb_stream;
  localparam int                  N        = 32;
  localparam int                  NUM_CB   = 10;
  localparam int                  MAX_LOG2 = 4;
  localparam logic [4*NUM_CB-1:0] CBB      = 40'h2334444444;
  localparam int BASE [10] = '{225, 325, 500, 700, 950, 1100, 1500, 2300, 2500, 2900};
  localparam int STEP [10] = '{25, 25, 50, 50, 50, 50, 100, 100, 100, 200};

  logic                clk = 1'b0;
  logic                rst, start, out_valid, out_ready, out_last, busy, done, sel_err;
  logic [3:0]          cb_sel;
  logic [N-1:0]        target, out_data;
  logic [MAX_LOG2-1:0] out_idx, best_idx;
  logic [N:0]          best_err;
  int                  n_pass = 0;
  int                  n_total = 0;

  always #5 clk = ~clk;

  lsp_cb_stream #(.N(N), .NUM_CB(NUM_CB), .MAX_LOG2(MAX_LOG2), .CB_BITS(CBB)) dut (
    .clk(clk), .rst(rst), .start(start), .cb_sel(cb_sel), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .sel_err(sel_err),
    .best_idx(best_idx), .best_err(best_err)
  );

  typedef struct {
    int          cb;
    int          mode;   // 0: ready high, 1: ready toggles, 2: ready random
    bit          spam;   // pulse start/cb_sel throughout the stream
    int          beats;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int exp_size(input int cb);
    logic [3:0] f;
    f = CBB[4*cb +: 4];
    return 1 << f;
  endfunction

  function automatic logic [N-1:0] exp_entry(input int cb, input int i);
    return N'((BASE[cb] + STEP[cb] * i) << 16);
  endfunction

  function automatic void model_best(input int cb, input logic [N-1:0] t,
                                     output int bi, output longint be);
    longint e, d;
    bi = 0;
    be = 0;
    for (int i = 0; i < exp_size(cb); i++) begin
      e = longint'($signed(exp_entry(cb, i)));
      d = e - longint'($signed(t));
      if (d < 0) d = -d;
      if (i == 0 || d < be) begin
        bi = i;
        be = d;
      end
    end
  endfunction

  task automatic run_stream(input int cb, input int mode, input logic [N-1:0] tgt, input bit spam,
                            output int beats, output logic [N-1:0] first_d, output logic [N-1:0] last_d);
    int  size, cyc, bi;
    longint be;
    bit  rdy;
    beats = 0; first_d = '0; last_d = '0; bi = 0; be = 0;
    @(negedge clk);
    start = 1'b1; cb_sel = 4'(cb); target = tgt; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (cb >= NUM_CB) begin
      check("sel_err_pulse", sel_err, 1);
      check("sel_err_busy", busy, 0);
      check("sel_err_valid", out_valid, 0);
      @(negedge clk);
      check("sel_err_clear", sel_err, 0);
      check("sel_err_idle", busy, 0);
      return;
    end
    size = exp_size(cb);
    check("fetch_busy", busy, 1);
    check("fetch_valid", out_valid, 0);
    cyc = 0;
    while (beats < size && cyc < 300) begin
      @(negedge clk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (spam) begin
        start  = ~start;
        cb_sel = 4'd9;
      end
      check($sformatf("cb%0d_valid_c%0d", cb, cyc), out_valid, 1);
      if (out_valid) begin
        check($sformatf("cb%0d_idx_c%0d", cb, cyc), out_idx, beats);
        if (rdy) begin
          check($sformatf("cb%0d_data_i%0d", cb, beats), out_data, exp_entry(cb, beats));
          check($sformatf("cb%0d_last_i%0d", cb, beats), out_last, beats == size - 1);
          if (beats == 0) first_d = out_data;
          last_d = out_data;
          beats++;
        end
      end
      cyc++;
    end
    check("beat_count", beats, size);
    if (mode == 0) check("throughput_cycles", cyc, size);
    @(negedge clk);
    out_ready = 1'b0;
    start = spam;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", out_valid, 0);
`ifdef LSP_CB_NEAREST_EN
    model_best(cb, tgt, bi, be);
    check("best_idx", best_idx, bi);
    check("best_err", best_err, be);
`else
    check("best_idx_off", best_idx, bi);
    check("best_err_off", best_err, be);
`endif
    @(negedge clk);
    start = 1'b0;
    check("done_clear", done, 0);
    check("idle_busy", busy, 0);
    if (spam) begin
      @(negedge clk);
      check("done_start_ignored", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int          beats;
    logic [N-1:0] fd, ld;
    bit          seen_done;

    rst = 1'b1; start = 1'b0; cb_sel = '0; target = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel_err", sel_err, 0);
    check("rst_best_idx", best_idx, 0);
    check("rst_best_err", best_err, 0);
    rst = 1'b0;

    vecs[0] = '{0, 0, 1'b0, 16, 32'h00E10000, 32'h02580000};
    vecs[1] = '{0, 1, 1'b0, 16, 32'h00E10000, 32'h02580000};
    vecs[2] = '{9, 0, 1'b0, 4,  32'h0B540000, 32'h0DAC0000};
    vecs[3] = '{12, 0, 1'b0, 0, 32'h00000000, 32'h00000000};
    vecs[4] = '{0, 0, 1'b1, 16, 32'h00E10000, 32'h02580000};
    vecs[5] = '{7, 1, 1'b0, 8,  32'h08FC0000, 32'h0BB80000};
    for (int k = 0; k < 6; k++) begin
      run_stream(vecs[k].cb, vecs[k].mode, 32'h01000000, vecs[k].spam, beats, fd, ld);
      check($sformatf("vec%0d_beats", k), beats, vecs[k].beats);
      check($sformatf("vec%0d_first", k), fd, vecs[k].first);
      check($sformatf("vec%0d_last", k), ld, vecs[k].last);
    end

    for (int r = 0; r < 20; r++) begin
      int cb;
      cb = $urandom_range(0, 11);
      run_stream(cb, 2, N'($urandom_range(0, 32'h0E000000)), 1'b0, beats, fd, ld);
      check($sformatf("rnd%0d_beats", r), beats, (cb < NUM_CB) ? exp_size(cb) : 0);
    end

    // Asynchronous reset in the middle of a cb0 stream.
    @(negedge clk);
    start = 1'b1; cb_sel = 4'd0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid && out_idx == 4'd7) break;
    end
    check("rst_mid_reach7", out_idx, 7);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    check("rst_mid_idx", out_idx, 0);
    check("rst_mid_last", out_last, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("rst_mid_no_done", seen_done, 0);
    run_stream(1, 0, 32'h01000000, 1'b0, beats, fd, ld);
    check("after_rst_beats", beats, 16);
    check("after_rst_first", fd, 32'h01450000);

`ifdef LSP_CB_NEAREST_EN
    run_stream(0, 0, 32'h01000000, 1'b0, beats, fd, ld);
    check("near256_idx", best_idx, 1);
    check("near256_err", best_err, 33'h000060000);
    run_stream(0, 1, 32'h00C80000, 1'b0, beats, fd, ld);
    check("near200_idx", best_idx, 0);
    run_stream(0, 2, 32'h00ED8000, 1'b0, beats, fd, ld);
    check("near_tie_idx", best_idx, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
